store_write_buffer: RTL and testbench

//  Posted-write FIFO between the MIPS core data port (memwrite/dataadr/writedata) and data memory.

---
 rtl/store_write_buffer_pkg.sv | 7 +
 rtl/store_write_buffer_fwd_match.sv | 50 +++++
 rtl/store_write_buffer.sv | 123 ++++++++++++
 tb/tb_store_write_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared word/byte-lane constants and default depth for the store write buffer.
package store_write_buffer_pkg;
    localparam int          WORD_W   = 32;
    localparam int          BE_W     = 4;
    localparam logic [3:0]  BE_FULL  = 4'b1111;
    localparam int          SB_DEPTH = 4;
endpackage

// File: rtl/store_write_buffer_fwd_match.sv
// Youngest-first address match over buffered stores for load forwarding.
import store_write_buffer_pkg::*;

module sb_fwd_match #(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                valid_i,
    input  logic [PTR_W-1:0]                wr_ptr_i,
    input  logic [DEPTH-1:0][ADDR_W-3:0]    ent_adr_i,
    input  logic [DEPTH-1:0][BE_W-1:0]      ent_be_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]    ent_data_i,
    input  logic [ADDR_W-1:0]               ld_adr_i,
    output logic                            hit_o,
    output logic                            conflict_o,
    output logic [DATA_W-1:0]               data_o
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;
    logic             unused_s;

    assign unused_s = ^ld_adr_i[1:0];

    // Walk from the newest slot (wr_ptr-1) backwards; first valid match decides.
    always_comb begin
        found_s    = 1'b0;
        idx_s      = '0;
        hit_o      = 1'b0;
        conflict_o = 1'b0;
        data_o     = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx_s = wr_ptr_i - PTR_W'(k);
            if (!found_s && valid_i[idx_s] && (ent_adr_i[idx_s] == ld_adr_i[ADDR_W-1:2])) begin
                found_s = 1'b1;
                if (ent_be_i[idx_s] == BE_FULL) begin
                    hit_o  = 1'b1;
                    data_o = ent_data_i[idx_s];
                end else begin
                    conflict_o = 1'b1;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core data port and data memory, with load forwarding.
import store_write_buffer_pkg::*;

module store_write_buffer #(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic [BE_W-1:0]   byteen,
    output logic              stall,
    input  logic [ADDR_W-1:0] ld_adr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_conflict,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ack,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-3:0] adr_q, adr_d;
    logic [DEPTH-1:0][BE_W-1:0]   be_q, be_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic                         push_s, pop_s;
    logic                         unused_s;

    assign unused_s = ^dataadr[1:0];

    // Status depends only on registered count, so stall has no path from mem_ack.
    assign stall   = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == {CNT_W{1'b0}});
    assign mem_req = !empty;
    assign push_s  = memwrite & !stall;
    assign pop_s   = mem_req & mem_ack;

    assign mem_adr   = mem_req ? {adr_q[rd_ptr_q], 2'b00} : {ADDR_W{1'b0}};
    assign mem_wdata = mem_req ? data_q[rd_ptr_q] : {DATA_W{1'b0}};
    assign mem_be    = mem_req ? be_q[rd_ptr_q] : {BE_W{1'b0}};

    // Next-state for storage, pointers, per-slot valid bits and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        adr_d    = adr_q;
        be_d     = be_q;
        data_d   = data_q;
        if (push_s) begin
            adr_d[wr_ptr_q]   = dataadr[ADDR_W-1:2];
            be_d[wr_ptr_q]    = byteen;
            data_d[wr_ptr_q]  = writedata;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        // A simultaneous push and pop never touch the same slot: that needs empty or full.
        if (pop_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every buffered store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            adr_q    <= '0;
            be_q     <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            adr_q    <= adr_d;
            be_q     <= be_d;
            data_q   <= data_d;
        end
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_fwd (
        .valid_i    (valid_q),
        .wr_ptr_i   (wr_ptr_q),
        .ent_adr_i  (adr_q),
        .ent_be_i   (be_q),
        .ent_data_i (data_q),
        .ld_adr_i   (ld_adr),
        .hit_o      (fwd_hit),
        .conflict_o (fwd_conflict),
        .data_o     (fwd_data)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: handshake, stall, ordering, forwarding, reset.
module tb_store_write_buffer;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [3:0]  byteen;
    logic        stall;
    logic [31:0] ld_adr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_conflict;
    logic        mem_req;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        empty;

    int checks = 0;
    int errors = 0;
    int sent;
    int cyc;
    logic accept;

    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic [3:0]  log_be[$];

    store_write_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .byteen       (byteen),
        .stall        (stall),
        .ld_adr       (ld_adr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .fwd_conflict (fwd_conflict),
        .mem_req      (mem_req),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write the memory side accepts.
    always @(posedge clk) begin
        if (reset && mem_req && mem_ack) begin
            log_adr.push_back(mem_adr);
            log_dat.push_back(mem_wdata);
            log_be.push_back(mem_be);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_adr.delete();
        log_dat.delete();
        log_be.delete();
    endtask

    initial begin
        reset     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
        byteen    = 4'hF;
        ld_adr    = 32'h0;
        mem_ack   = 1'b0;
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
        chk("rst_fwd_conflict", {31'd0, fwd_conflict}, 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        step();
        reset = 1'b1;

        // Reset mid-drain discards buffered stores.
        for (int i = 0; i < 3; i++) begin
            memwrite  = 1'b1;
            dataadr   = 32'h100 + 32'(4 * i);
            writedata = 32'hA0 + 32'(i);
            step();
        end
        memwrite = 1'b0;
        chk("t1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_head", mem_adr, 32'h100);
        mem_ack = 1'b1;
        step();
        clear_log();
        #2 reset = 1'b0;
        #1;
        chk("t1_req_async", {31'd0, mem_req}, 32'd0);
        chk("t1_empty_async", {31'd0, empty}, 32'd1);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t1_nothing_drained", 32'(log_adr.size()), 32'd0);
        chk("t1_empty_after", {31'd0, empty}, 32'd1);

        // Single store with ack tied high.
        mem_ack   = 1'b1;
        memwrite  = 1'b1;
        dataadr   = 32'h18;
        writedata = 32'd21;
        byteen    = 4'hF;
        chk("t2_no_bypass", {31'd0, mem_req}, 32'd0);
        step();
        memwrite = 1'b0;
        chk("t2_req", {31'd0, mem_req}, 32'd1);
        chk("t2_adr", mem_adr, 32'h18);
        chk("t2_wdata", mem_wdata, 32'd21);
        chk("t2_be", {28'd0, mem_be}, 32'hF);
        ld_adr = 32'h18;
        #1;
        chk("t2_fwd_while_acked", {31'd0, fwd_hit}, 32'd1);
        chk("t2_fwd_data", fwd_data, 32'd21);
        step();
        chk("t2_empty", {31'd0, empty}, 32'd1);
        chk("t2_log_n", 32'(log_adr.size()), 32'd1);
        if (log_adr.size() == 1) chk("t2_log_adr", log_adr[0], 32'h18);
        clear_log();

        // Fill to full, hold the fifth store, then full+ack+memwrite.
        mem_ack = 1'b0;
        ld_adr  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            memwrite  = 1'b1;
            dataadr   = 32'h40 + 32'(4 * i);
            writedata = 32'h300 + 32'(i);
            chk("t3_not_full", {31'd0, stall}, 32'd0);
            step();
        end
        chk("t3_full", {31'd0, stall}, 32'd1);
        dataadr   = 32'h50;
        writedata = 32'h304;
        step();
        chk("t3_still_full", {31'd0, stall}, 32'd1);
        chk("t3_head_held", mem_adr, 32'h40);
        mem_ack = 1'b1;
        step();
        chk("t4_deq_only", {31'd0, stall}, 32'd0);
        chk("t4_head", mem_adr, 32'h44);
        step();
        memwrite = 1'b0;
        chk("t4_retry_stall", {31'd0, stall}, 32'd0);
        chk("t4_head2", mem_adr, 32'h48);
        for (int i = 0; i < 3; i++) step();
        chk("t3_empty", {31'd0, empty}, 32'd1);
        chk("t3_log_n", 32'(log_adr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_adr.size()) begin
                chk("t3_order_adr", log_adr[i], 32'h40 + 32'(4 * i));
                chk("t3_order_dat", log_dat[i], 32'h300 + 32'(i));
            end
        end
        clear_log();

        // Forwarding: youngest full-word wins; partial youngest conflicts.
        mem_ack   = 1'b0;
        memwrite  = 1'b1;
        dataadr   = 32'h54;
        writedata = 32'd7;
        byteen    = 4'hF;
        ld_adr    = 32'h54;
        #1;
        chk("t5_not_yet_visible", {31'd0, fwd_hit}, 32'd0);
        step();
        writedata = 32'd9;
        #1;
        chk("t5_old_hit", {31'd0, fwd_hit}, 32'd1);
        chk("t5_old_data", fwd_data, 32'd7);
        step();
        memwrite = 1'b0;
        #1;
        chk("t5_hit", {31'd0, fwd_hit}, 32'd1);
        chk("t5_data", fwd_data, 32'd9);
        chk("t5_no_conflict", {31'd0, fwd_conflict}, 32'd0);
        ld_adr = 32'h57;
        #1;
        chk("t5_lowbits_data", fwd_data, 32'd9);
        ld_adr = 32'h58;
        #1;
        chk("t5_miss_hit", {31'd0, fwd_hit}, 32'd0);
        chk("t5_miss_data", fwd_data, 32'd0);
        chk("t5_miss_conflict", {31'd0, fwd_conflict}, 32'd0);
        memwrite  = 1'b1;
        dataadr   = 32'h54;
        writedata = 32'hAA;
        byteen    = 4'b0011;
        ld_adr    = 32'h54;
        step();
        memwrite = 1'b0;
        byteen   = 4'hF;
        #1;
        chk("t5_conflict", {31'd0, fwd_conflict}, 32'd1);
        chk("t5_conflict_nohit", {31'd0, fwd_hit}, 32'd0);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t5_empty", {31'd0, empty}, 32'd1);
        chk("t5_drained_conflict", {31'd0, fwd_conflict}, 32'd0);
        chk("t5_log_n", 32'(log_adr.size()), 32'd3);
        if (log_be.size() == 3) chk("t5_partial_be", {28'd0, log_be[2]}, 32'h3);
        clear_log();

        // Ten stores through the wrapping pointers with random ack gaps.
        sent = 0;
        cyc  = 0;
        while ((sent < 10 || !empty) && cyc < 300) begin
            memwrite  = (sent < 10);
            dataadr   = 32'h200 + 32'(4 * sent);
            writedata = 32'h5000 + 32'(sent);
            mem_ack   = ($urandom_range(0, 3) == 0);
            accept    = memwrite && !stall;
            step();
            if (accept) sent++;
            cyc++;
        end
        memwrite = 1'b0;
        mem_ack  = 1'b0;
        chk("t6_no_timeout", {31'd0, (cyc < 300)}, 32'd1);
        chk("t6_log_n", 32'(log_adr.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < log_adr.size()) begin
                chk("t6_adr", log_adr[i], 32'h200 + 32'(4 * i));
                chk("t6_dat", log_dat[i], 32'h5000 + 32'(i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
